// File: rtl/uart_read_if.sv
// Purpose: CPU-side byte handshake between the UART receiver and its consumer.
// Latency: none; plain wires grouped under one name.
// Backpressure: read_ce acknowledges and pops the held byte while rfin is high.
//
// Signals:
//   read_ce  consumer acknowledge, pops the held byte
//   dout     received byte, valid while rfin = 1
//   rfin     byte available, level held until acknowledged
//   ferr     framing-error pulse, one cycle wide
//   overrun  sticky flag: a held byte was overwritten before it was read
interface uart_read_if;
    logic       read_ce;
    logic [7:0] dout;
    logic       rfin;
    logic       ferr;
    logic       overrun;

    // master: the receiver; slave: the consumer reading bytes out
    modport master (input read_ce, output dout, output rfin, output ferr, output overrun);
    modport slave  (output read_ce, input dout, input rfin, input ferr, input overrun);
endinterface

// File: rtl/uart_read.sv
// Purpose: 8N1 UART receiver, OVERSAMPLE clocks per bit, one-entry byte holding register.
// Latency: rfin rises 9.5*OVERSAMPLE + 3 cycles after the din falling edge (155 at 16x).
// Backpressure: none on the line; an unread byte is overwritten and overrun is flagged.
//
// Ports:
//   clk  system clock at OVERSAMPLE x bit rate
//   rst  asynchronous reset, active low
//   din  serial line, asynchronous to clk, idle high
//   rx   byte handshake (read_ce in; dout, rfin, ferr, overrun out)
//
// OVERSAMPLE must be even and >= 8, and 2**CNT_W must be >= OVERSAMPLE.
module uart_read #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    uart_read_if.master  rx
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             byte_done;
    logic             frame_err;

    logic             sync1, rx_s, rx_prev;

    logic [7:0]       dout_q;
    logic             rfin_q;
    logic             ferr_q;
    logic             overrun_q;

    // Two-flop synchroniser plus edge-detect flop; all reset to the idle-high
    // line level so coming out of reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= din;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                // Only a genuine 1->0 transition starts a frame, so a line
                // stuck low (break, or after a framing error) stays ignored.
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    if (rx_s) begin
                        state_nxt = IDLE;       // glitch, not a start bit
                    end else begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                // Counter was re-zeroed at mid start bit, so a full period
                // later lands at the middle of each data bit.
                if (cnt == FULL_M1) begin
                    shreg_nxt = {rx_s, shreg[7:1]};
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Holding register. A byte landing in the same cycle as an acknowledge
    // replaces the popped byte, so it is not an overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q    <= 8'h00;
            rfin_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ferr_q <= frame_err;
            if (byte_done) begin
                dout_q <= shreg;
                rfin_q <= 1'b1;
                if (rfin_q) begin
                    overrun_q <= ~rx.read_ce;
                end
            end else if (rfin_q && rx.read_ce) begin
                rfin_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx.dout    = dout_q;
    assign rx.rfin    = rfin_q;
    assign rx.ferr    = ferr_q;
    assign rx.overrun = overrun_q;

endmodule
